// File: rtl/parity_acc_if.sv
// parity_acc_if: beat/result bus between a frame producer and parity_acc.
// With PARITY_ACC_CHECK_EN defined, the bus also carries the expected parity
// (p) and the mismatch flag (err).
interface parity_acc_if #(
  parameter int WIDTH = 5,
  parameter int CNTW  = 8
);
  logic [WIDTH-1:0] d;
  logic             valid;
  logic             last;
  logic             rdy;
  logic             z;
  logic             zv;
  logic             zack;
  logic [CNTW-1:0]  beats;
`ifdef PARITY_ACC_CHECK_EN
  logic             p;
  logic             err;
`endif

  modport master (
    output d, valid, last, zack,
`ifdef PARITY_ACC_CHECK_EN
    output p,
    input  err,
`endif
    input  rdy, z, zv, beats
  );

  modport slave (
    input  d, valid, last, zack,
`ifdef PARITY_ACC_CHECK_EN
    input  p,
    output err,
`endif
    output rdy, z, zv, beats
  );
endinterface

// File: rtl/parity_acc.sv
// parity_acc: accumulates the parity of a multi-beat frame and reports it
// together with a saturating beat count once the LAST beat is accepted.
// The result is held until the consumer acknowledges it; a new LAST beat in
// the acknowledge cycle replaces the result back-to-back.
// Optional feature macro: PARITY_ACC_CHECK_EN adds the expected-parity input
// and the mismatch flag.
//
// state   | meaning
// S_EMPTY | no result pending, beats always accepted
// S_FULL  | result pending (zv=1), beats accepted only with zack
module parity_acc #(
  parameter int WIDTH = 5,
  parameter int ODD   = 0,
  parameter int CNTW  = 8
) (
  input logic         clk_i,
  input logic         rstn_i,
  parity_acc_if.slave bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam logic            ODD_BIT = (ODD != 0);
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic            acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] beats_q, beats_d;
  logic            z_q, z_d;
  logic            beat_par;
  logic            frame_par;
  logic            rdy;
  logic            accept;
  logic [CNTW-1:0] cnt_inc;
`ifdef PARITY_ACC_CHECK_EN
  logic            err_q, err_d;
`endif

  assign beat_par  = ^bus.d;
  assign frame_par = acc_q ^ beat_par ^ ODD_BIT;
  assign rdy       = (state_q == S_EMPTY) | bus.zack;
  assign accept    = bus.valid & rdy;
  // Counter sticks at all-ones so long frames report the maximum count.
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

  assign bus.rdy   = rdy;
  assign bus.zv    = (state_q == S_FULL);
  assign bus.z     = z_q;
  assign bus.beats = beats_q;
`ifdef PARITY_ACC_CHECK_EN
  assign bus.err   = err_q;
`endif

  // Registers: frame accumulator, beat counter, held result and state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_EMPTY;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      beats_q <= '0;
      z_q     <= 1'b0;
`ifdef PARITY_ACC_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      z_q     <= z_d;
`ifdef PARITY_ACC_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next state: fold accepted beats into the frame; LAST publishes the
  // result and restarts the frame, an acknowledge alone frees the result.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    z_d     = z_q;
`ifdef PARITY_ACC_CHECK_EN
    err_d   = err_q;
`endif

    if ((state_q == S_FULL) && bus.zack) begin
      state_d = S_EMPTY;
    end

    if (accept) begin
      if (bus.last) begin
        z_d     = frame_par;
        beats_d = cnt_inc;
        acc_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_FULL;
`ifdef PARITY_ACC_CHECK_EN
        err_d   = (frame_par != bus.p);
`endif
      end else begin
        acc_d = acc_q ^ beat_par;
        cnt_d = cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_parity_acc.sv
module tb_parity_acc;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic [4:0] d = '0;
  logic       zack = 1'b0;
  logic       p = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Three instances share stimulus: A (ODD=0,CNTW=8), B (ODD=0,CNTW=2), C (ODD=1,CNTW=8).
  parity_acc_if #(.WIDTH(5), .CNTW(8)) if_a ();
  parity_acc_if #(.WIDTH(5), .CNTW(2)) if_b ();
  parity_acc_if #(.WIDTH(5), .CNTW(8)) if_c ();

  parity_acc #(.WIDTH(5), .ODD(0), .CNTW(8)) dut_a (.clk_i(clk), .rstn_i(rstn), .bus(if_a));
  parity_acc #(.WIDTH(5), .ODD(0), .CNTW(2)) dut_b (.clk_i(clk), .rstn_i(rstn), .bus(if_b));
  parity_acc #(.WIDTH(5), .ODD(1), .CNTW(8)) dut_c (.clk_i(clk), .rstn_i(rstn), .bus(if_c));

  assign if_a.d = d;  assign if_a.valid = valid;  assign if_a.last = last;  assign if_a.zack = zack;
  assign if_b.d = d;  assign if_b.valid = valid;  assign if_b.last = last;  assign if_b.zack = zack;
  assign if_c.d = d;  assign if_c.valid = valid;  assign if_c.last = last;  assign if_c.zack = zack;

  logic       act_rdy [3];
  logic       act_zv  [3];
  logic       act_z   [3];
  logic [7:0] act_beats [3];
  logic       act_err [3];

  assign act_rdy[0] = if_a.rdy;  assign act_rdy[1] = if_b.rdy;  assign act_rdy[2] = if_c.rdy;
  assign act_zv[0]  = if_a.zv;   assign act_zv[1]  = if_b.zv;   assign act_zv[2]  = if_c.zv;
  assign act_z[0]   = if_a.z;    assign act_z[1]   = if_b.z;    assign act_z[2]   = if_c.z;
  assign act_beats[0] = if_a.beats;
  assign act_beats[1] = {6'b0, if_b.beats};
  assign act_beats[2] = if_c.beats;
`ifdef PARITY_ACC_CHECK_EN
  assign if_a.p = p;  assign if_b.p = p;  assign if_c.p = p;
  assign act_err[0] = if_a.err;  assign act_err[1] = if_b.err;  assign act_err[2] = if_c.err;
`else
  assign act_err[0] = 1'b0;  assign act_err[1] = 1'b0;  assign act_err[2] = 1'b0;
`endif

  // Reference model: frame kept as a list of beats, results derived on LAST.
  int       odd_k  [3] = '{0, 0, 1};
  int       cntw_k [3] = '{8, 2, 8};
  bit       m_zv;
  int       m_z     [3];
  int       m_beats [3];
  int       m_err   [3];
  int       frame_q [$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_zv = 1'b0;
    frame_q.delete();
    for (int k = 0; k < 3; k++) begin
      m_z[k] = 0;  m_beats[k] = 0;  m_err[k] = 0;
    end
  endtask

  task automatic model_step();
    bit m_rdy;
    int ones;
    int maxc;
    m_rdy = !m_zv || zack;
    if (m_zv && zack) m_zv = 1'b0;
    if (valid && m_rdy) begin
      frame_q.push_back(int'(d));
      if (last) begin
        ones = 0;
        foreach (frame_q[i]) ones += $countones(frame_q[i]);
        for (int k = 0; k < 3; k++) begin
          maxc = (1 << cntw_k[k]) - 1;
          m_z[k]     = (ones + odd_k[k]) % 2;
          m_beats[k] = (frame_q.size() > maxc) ? maxc : frame_q.size();
          m_err[k]   = (m_z[k] != int'(p)) ? 1 : 0;
        end
        m_zv = 1'b1;
        frame_q.delete();
      end
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_zv[%0d]", k), int'(act_zv[k]), int'(m_zv));
      if (m_zv) begin
        chk($sformatf("model_z[%0d]", k), int'(act_z[k]), m_z[k]);
        chk($sformatf("model_beats[%0d]", k), int'(act_beats[k]), m_beats[k]);
`ifdef PARITY_ACC_CHECK_EN
        chk($sformatf("model_err[%0d]", k), int'(act_err[k]), m_err[k]);
`endif
      end
    end
  endtask

  // One clock: drive inputs, check rdy, advance model, check outputs after edge.
  task automatic cycle(input logic v, input logic l, input logic [4:0] dd,
                       input logic za, input logic pp);
    valid = v;  last = l;  d = dd;  zack = za;  p = pp;
    #2;
    for (int k = 0; k < 3; k++)
      chk($sformatf("rdy[%0d]", k), int'(act_rdy[k]), int'(!m_zv || za));
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  typedef struct {
    logic       v, l;
    logic [4:0] d;
    logic       za, p;
    logic       zv, z0, z1;
    int         b, b2;
    logic       e;
  } vec_t;

  function automatic vec_t mk(input int v, input int l, input int dd, input int za,
                              input int pp, input int zv, input int z0, input int z1,
                              input int b, input int b2, input int e);
    vec_t r;
    r.v = v[0];  r.l = l[0];  r.d = dd[4:0];  r.za = za[0];  r.p = pp[0];
    r.zv = zv[0];  r.z0 = z0[0];  r.z1 = z1[0];  r.b = b;  r.b2 = b2;  r.e = e[0];
    return r;
  endfunction

  vec_t tbl [$];

  initial begin
    //                v  l  d         za p  zv z0 z1 b  b2 e
    tbl.push_back(mk(1, 1, 5'b10110, 0, 0, 1, 1, 0, 1, 1, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 0, 5'b11111, 0, 0, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 5'b00000, 1, 0, 1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 5'b00011, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5'b00111, 0, 0, 1, 0, 1, 3, 3, 0));
    tbl.push_back(mk(0, 0, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5'b00001, 0, 0, 1, 0, 1, 6, 3, 0));
    tbl.push_back(mk(1, 0, 5'b00001, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5'b00010, 0, 0, 1, 0, 1, 2, 2, 0));
    tbl.push_back(mk(1, 1, 5'b11100, 1, 0, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 5'b11000, 1, 0, 1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 0));

    model_reset();
    #3;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_zv[%0d]", k), int'(act_zv[k]), 0);
      chk($sformatf("reset_z[%0d]", k), int'(act_z[k]), 0);
      chk($sformatf("reset_beats[%0d]", k), int'(act_beats[k]), 0);
      chk($sformatf("reset_err[%0d]", k), int'(act_err[k]), 0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Directed table.
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].za, tbl[i].p);
      chk($sformatf("tbl%0d_zv", i), int'(act_zv[0]), int'(tbl[i].zv));
      if (tbl[i].zv) begin
        chk($sformatf("tbl%0d_z_even", i), int'(act_z[0]), int'(tbl[i].z0));
        chk($sformatf("tbl%0d_z_odd", i), int'(act_z[2]), int'(tbl[i].z1));
        chk($sformatf("tbl%0d_beats", i), int'(act_beats[0]), tbl[i].b);
        chk($sformatf("tbl%0d_beats_sat", i), int'(act_beats[1]), tbl[i].b2);
`ifdef PARITY_ACC_CHECK_EN
        chk($sformatf("tbl%0d_err", i), int'(act_err[0]), int'(tbl[i].e));
`endif
      end
    end

    // Reset mid-frame: two beats, async reset, then a single-beat frame.
    cycle(1, 0, 5'b00001, 0, 0);
    cycle(1, 0, 5'b00011, 0, 0);
    valid = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_rst_zv[%0d]", k), int'(act_zv[k]), 0);
      chk($sformatf("async_rst_beats[%0d]", k), int'(act_beats[k]), 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cycle(1, 1, 5'b00001, 0, 1);
    chk("post_rst_zv", int'(act_zv[0]), 1);
    chk("post_rst_z", int'(act_z[0]), 1);
    chk("post_rst_beats", int'(act_beats[0]), 1);
    chk("post_rst_z_odd", int'(act_z[2]), 0);
    cycle(0, 0, 5'b00000, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) == 0),
            5'($urandom), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
